stopwatch_ctrl: RTL and testbench

Control and sequencing block for the stopwatch datapath. It turns debounced start/stop, clear and lap buttons into a run/pause/idle state machine and divides the system clock into 10 ms ticks. It maintains the 0..9999 centisecond count and drives it into the 14-bit binary-to-BCD converter. It then scans the converter's four BCD nibbles onto a 4-digit multiplexed 7-segment display.

---
 rtl/stopwatch_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: button edge detection, IDLE/RUN/PAUSE control, 10 ms tick
// prescaler, centisecond count with lap snapshot, and 4-digit multiplexed display scan.
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 1000000,
    parameter int SCAN_DIV  = 100000,
    parameter int MAX_COUNT = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start_stop,
    input  logic        btn_clear,
    input  logic        btn_lap,
    input  logic [15:0] bcd_in,
    output logic [13:0] count_value,
    output logic [3:0]  anode,
    output logic [3:0]  digit,
    output logic        running,
    output logic        lap_active
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [13:0]   COUNT_MAX = 14'(MAX_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    btn_q;
    logic          req_ss_s, req_clr_s, req_lap_s;
    logic [PW-1:0] presc_q, presc_d;
    logic [13:0]   count_q, count_d;
    logic [13:0]   lap_reg_q, lap_reg_d;
    logic          lap_active_q, lap_active_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    scan_idx_q, scan_idx_d;
    logic [3:0]    anode_q, anode_d;
    logic          tick_s;
    logic          running_s;

    assign req_ss_s  = btn_start_stop & ~btn_q[0];
    assign req_clr_s = btn_clear      & ~btn_q[1];
    assign req_lap_s = btn_lap        & ~btn_q[2];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; clear outranks start/stop except in RUN where clear is dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_ss_s && !req_clr_s) state_d = ST_RUN;
                else                        state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (req_ss_s) state_d = ST_PAUSE;
                else          state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (req_clr_s)     state_d = ST_IDLE;
                else if (req_ss_s) state_d = ST_RUN;
                else               state_d = ST_PAUSE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        running_s = 1'b0;
        case (state_q)
            ST_RUN:  running_s = 1'b1;
            default: running_s = 1'b0;
        endcase
    end

    // Prescaler, count and lap next-state; all decisions use the pre-transition state
    always_comb begin
        presc_d      = presc_q;
        count_d      = count_q;
        lap_reg_d    = lap_reg_q;
        lap_active_d = lap_active_q;
        tick_s       = 1'b0;

        if (state_q == ST_RUN) begin
            if (presc_q == TICK_LAST) begin
                presc_d = {PW{1'b0}};
                tick_s  = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else if (state_q == ST_IDLE && state_d == ST_RUN) begin
            presc_d = {PW{1'b0}};
        end else begin
            presc_d = presc_q;
        end

        if (state_q != ST_RUN && req_clr_s) begin
            count_d = 14'd0;
        end else if (tick_s) begin
            count_d = (count_q >= COUNT_MAX) ? 14'd0 : count_q + 14'd1;
        end else begin
            count_d = count_q;
        end

        if (state_q == ST_PAUSE && req_clr_s) begin
            lap_reg_d    = 14'd0;
            lap_active_d = 1'b0;
        end else if (req_lap_s) begin
            if (state_q == ST_RUN && !lap_active_q) begin
                lap_reg_d    = count_q;
                lap_active_d = 1'b1;
            end else begin
                lap_active_d = 1'b0;
            end
        end else begin
            lap_active_d = lap_active_q;
        end
    end

    // Display scan next-state; anode is precomputed so it flips with scan_idx
    always_comb begin
        scan_cnt_d = scan_cnt_q;
        scan_idx_d = scan_idx_q;
        anode_d    = anode_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = {SW{1'b0}};
            scan_idx_d = scan_idx_q + 2'd1;
            anode_d    = ~(4'b0001 << (scan_idx_q + 2'd1));
        end else begin
            scan_cnt_d = scan_cnt_q + SW'(1);
        end
    end

    // Datapath and scan registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q        <= 3'b000;
            presc_q      <= {PW{1'b0}};
            count_q      <= 14'd0;
            lap_reg_q    <= 14'd0;
            lap_active_q <= 1'b0;
            scan_cnt_q   <= {SW{1'b0}};
            scan_idx_q   <= 2'd0;
            anode_q      <= 4'b1110;
        end else begin
            btn_q        <= {btn_lap, btn_clear, btn_start_stop};
            presc_q      <= presc_d;
            count_q      <= count_d;
            lap_reg_q    <= lap_reg_d;
            lap_active_q <= lap_active_d;
            scan_cnt_q   <= scan_cnt_d;
            scan_idx_q   <= scan_idx_d;
            anode_q      <= anode_d;
        end
    end

    // Digit select from the converter nibbles
    always_comb begin
        digit = 4'd0;
        case (scan_idx_q)
            2'd0:    digit = bcd_in[3:0];
            2'd1:    digit = bcd_in[7:4];
            2'd2:    digit = bcd_in[11:8];
            2'd3:    digit = bcd_in[15:12];
            default: digit = 4'd0;
        endcase
    end

    assign count_value = lap_active_q ? lap_reg_q : count_q;
    assign anode       = anode_q;
    assign running     = running_s;
    assign lap_active  = lap_active_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with small dividers (TICK 4, SCAN 2, MAX 12).
module tb_stopwatch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        btn_start_stop, btn_clear, btn_lap;
    logic [15:0] bcd_in;
    logic [13:0] count_value;
    logic [3:0]  anode, digit;
    logic        running, lap_active;

    logic        force_bcd;
    logic [15:0] bcd_force;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        ss, clr, lap;
        int          cyc;
        logic [13:0] cv;
        logic        run, lapa;
    } vec_t;

    typedef struct {
        string       name;
        logic [13:0] cv;
        logic        run, lapa;
    } exp_t;

    vec_t vecs[19];
    exp_t sb_q[$];

    stopwatch_ctrl #(.TICK_DIV(4), .SCAN_DIV(2), .MAX_COUNT(12)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_start_stop (btn_start_stop),
        .btn_clear      (btn_clear),
        .btn_lap        (btn_lap),
        .bcd_in         (bcd_in),
        .count_value    (count_value),
        .anode          (anode),
        .digit          (digit),
        .running        (running),
        .lap_active     (lap_active)
    );

    function automatic logic [15:0] bin2bcd(input logic [13:0] v);
        int x;
        x = int'(v);
        return {4'((x / 1000) % 10), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    assign bcd_in = force_bcd ? bcd_force : bin2bcd(count_value);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string name, input logic [13:0] cv, input logic run, input logic lapa);
        exp_t e;
        e.name = name; e.cv = cv; e.run = run; e.lapa = lapa;
        sb_q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got no expectation, need one");
        end else begin
            e = sb_q.pop_front();
            if (count_value !== e.cv || running !== e.run || lap_active !== e.lapa) begin
                n_fail++;
                $display("FAIL %s: got cv=%0d run=%b lap=%b, need cv=%0d run=%b lap=%b",
                         e.name, count_value, running, lap_active, e.cv, e.run, e.lapa);
            end
        end
    endtask

    task automatic cmp8(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, need %h", name, act, req);
        end
    endtask

    initial begin
        logic [15:0] pat;
        logic [3:0]  prev_an;
        logic [1:0]  idx;
        bit          found;

        rst_n = 1'b0;
        btn_start_stop = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
        force_bcd = 1'b0; bcd_force = 16'h0000;

        //        ss    clr   lap   cyc  cv      run   lapa
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 41, 14'd10, 1'b1, 1'b0};  // start, 10 ticks
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 20, 14'd10, 1'b0, 1'b0};  // pause holds
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 3,  14'd10, 1'b1, 1'b0};  // resume, prescaler at 3
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1,  14'd11, 1'b1, 1'b0};  // remaining prescaler tick
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 4,  14'd12, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 4,  14'd0,  1'b1, 1'b0};  // wrap at MAX_COUNT
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 20, 14'd5,  1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1,  14'd5,  1'b1, 1'b1};  // lap snapshot
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 15, 14'd5,  1'b1, 1'b1};  // frozen while count -> 9
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1,  14'd9,  1'b1, 1'b0};  // second lap -> live
        vecs[10] = '{1'b0, 1'b0, 1'b0, 3,  14'd10, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1,  14'd10, 1'b1, 1'b0};  // clear ignored in RUN
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1,  14'd10, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1,  14'd10, 1'b0, 1'b1};  // pause keeps lap
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1,  14'd10, 1'b0, 1'b0};  // lap in PAUSE clears
        vecs[15] = '{1'b1, 1'b1, 1'b0, 2,  14'd0,  1'b0, 1'b0};  // clear beats start/stop
        vecs[16] = '{1'b0, 1'b1, 1'b0, 5,  14'd0,  1'b0, 1'b0};  // clear in IDLE
        vecs[17] = '{1'b0, 1'b0, 1'b0, 10, 14'd0,  1'b0, 1'b0};  // no counting in IDLE
        vecs[18] = '{1'b1, 1'b0, 1'b0, 5,  14'd1,  1'b1, 1'b0};  // first tick 4 edges after entry

        repeat (2) @(negedge clk);
        push_exp("reset_state", 14'd0, 1'b0, 1'b0);
        check_pop();
        cmp8("reset_anode", {4'd0, anode}, 8'h0E);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            btn_start_stop = vecs[i].ss;
            btn_clear      = vecs[i].clr;
            btn_lap        = vecs[i].lap;
            push_exp($sformatf("vec%0d", i), vecs[i].cv, vecs[i].run, vecs[i].lapa);
            @(negedge clk);
            btn_start_stop = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
            repeat (vecs[i].cyc - 1) @(negedge clk);
            check_pop();
        end

        // Held start/stop gives exactly one toggle
        btn_start_stop = 1'b1;
        push_exp("held_button", 14'd1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check_pop();
        btn_start_stop = 1'b0;
        push_exp("held_release", 14'd1, 1'b0, 1'b0);
        @(negedge clk);
        check_pop();

        // Resume, take a lap, then assert reset mid-cycle
        btn_start_stop = 1'b1;
        push_exp("resume_run", 14'd4, 1'b1, 1'b0);
        @(negedge clk);
        btn_start_stop = 1'b0;
        repeat (11) @(negedge clk);
        check_pop();
        btn_lap = 1'b1;
        push_exp("lap_before_reset", 14'd4, 1'b1, 1'b1);
        @(negedge clk);
        btn_lap = 1'b0;
        check_pop();
        #2 rst_n = 1'b0;
        #1;
        push_exp("async_reset", 14'd0, 1'b0, 1'b0);
        check_pop();
        cmp8("async_reset_anode", {4'd0, anode}, 8'h0E);
        @(negedge clk);
        rst_n = 1'b1;
        push_exp("idle_after_reset", 14'd0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check_pop();

        // Display scan with a fixed converter pattern
        force_bcd = 1'b1;
        bcd_force = 16'h1234;
        pat = 16'h1234;
        found = 1'b0;
        prev_an = anode;
        for (int w = 0; w < 20 && !found; w++) begin
            @(negedge clk);
            if (anode == 4'b1101 && prev_an != 4'b1101) found = 1'b1;
            else prev_an = anode;
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL scan_sync: got no anode step to 1101 within 20 cycles, need one");
        end else begin
            for (int k = 0; k < 8; k++) begin
                idx = 2'(1 + k / 2);
                cmp8($sformatf("scan%0d", k), {anode, digit}, {~(4'b0001 << idx), pat[4*idx +: 4]});
                @(negedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
